// File: rtl/lamp_fpu_sqrt_round_pack_pkg.sv
// Shared widths, result-entry layout and the stage-2 round/pack arithmetic
// for the sqrt result back-end.
package lamp_fpu_sqrt_round_pack_pkg;

  localparam int unsigned LAMP_FLOAT_S_W = 1;
  localparam int unsigned LAMP_FLOAT_E_W = 8;
  localparam int unsigned LAMP_FLOAT_F_W = 7;
  localparam int unsigned RND_GRS_W      = 3;
  localparam int unsigned BF16_W         = LAMP_FLOAT_S_W + LAMP_FLOAT_E_W + LAMP_FLOAT_F_W;
  localparam int unsigned EXT_F_W        = 1 + LAMP_FLOAT_F_W + RND_GRS_W + 1;

  localparam logic [LAMP_FLOAT_E_W-1:0] INF_E  = 8'hFF;
  localparam logic [LAMP_FLOAT_E_W-1:0] ZERO_E = 8'h00;
  localparam logic [LAMP_FLOAT_F_W-1:0] ZERO_F = 7'h00;

  typedef struct packed {
    logic [BF16_W-1:0] res;
    logic              inexact;
    logic              ovf;
    logic              unf;
  } res_entry_t;

  localparam int unsigned RES_ENTRY_W = $bits(res_entry_t);

  // Round-to-nearest-even on an already single-step-normalized significand,
  // then saturate to infinity / flush to zero and pack.
  function automatic res_entry_t round_pack_sqrt(
    input logic                      s,
    input logic [LAMP_FLOAT_E_W-1:0] e,
    input logic [EXT_F_W-1:0]        f,
    input logic                      rnd,
    input logic                      unf
  );
    res_entry_t                o;
    logic                      g;
    logic                      r;
    logic                      st;
    logic                      ru;
    logic                      carry;
    logic [LAMP_FLOAT_F_W:0]   frac_sum;
    logic [LAMP_FLOAT_E_W:0]   e_r;
    o        = '0;
    g        = f[3];
    r        = f[2];
    st       = |f[1:0];
    ru       = g & (r | st | f[4]);
    frac_sum = {1'b0, f[10:4]} + 8'(ru);
    carry    = frac_sum[LAMP_FLOAT_F_W];
    e_r      = {1'b0, e} + 9'(carry);
    if (!rnd) begin
      o.res = {s, e, f[11:5]};
    end else if (unf) begin
      o.res     = {s, ZERO_E, ZERO_F};
      o.inexact = 1'b1;
      o.unf     = 1'b1;
    end else if (e_r >= 9'(INF_E)) begin
      o.res     = {s, INF_E, ZERO_F};
      o.inexact = 1'b1;
      o.ovf     = 1'b1;
    end else begin
      o.res     = {s, e_r[LAMP_FLOAT_E_W-1:0], frac_sum[LAMP_FLOAT_F_W-1:0]};
      o.inexact = g | r | st;
    end
    return o;
  endfunction

endpackage

// File: rtl/lamp_fpu_sqrt_round_pack_res_fifo.sv
// Show-ahead synchronous FIFO; a push on full is accepted only when a pop
// frees a slot in the same cycle, a pop on empty is ignored.
module lamp_fpu_sqrt_round_pack_res_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt_c;
  logic             do_push_c;
  logic             do_pop_c;

  always_comb begin
    do_pop_c    = pop & ~empty;
    do_push_c   = push & (~full | do_pop_c);
    count_nxt_c = count + CW'(do_push_c) - CW'(do_pop_c);
  end

  assign head_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

  // Flags are registered from the next occupancy so they come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

endmodule

// File: rtl/lamp_fpu_sqrt_round_pack.sv
// Sqrt result back-end: normalize, round-to-nearest-even, pack to bfloat16
// and buffer behind a valid/ready port; drops with sticky overrun when full.
module lamp_fpu_sqrt_round_pack
  import lamp_fpu_sqrt_round_pack_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic                      s_i,
  input  logic [LAMP_FLOAT_E_W-1:0] e_i,
  input  logic [EXT_F_W-1:0]        f_i,
  input  logic                      isToRound_i,
  output logic [BF16_W-1:0]         res_o,
  output logic                      inexact_o,
  output logic                      ovf_o,
  output logic                      unf_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      overrun_o
);

  logic                      v1;
  logic                      s1;
  logic                      rnd1;
  logic                      unf1;
  logic [LAMP_FLOAT_E_W-1:0] e1;
  logic [EXT_F_W-1:0]        f1;
  logic                      norm_c;
  logic                      unf_c;
  res_entry_t                entry_c;
  res_entry_t                head_c;
  logic [RES_ENTRY_W-1:0]    head_raw_c;
  logic                      pop_c;
  logic                      full;
  logic                      empty;
  logic                      overrun;

  // Single-step normalization; exponent 0 or a decrement through 0 flushes.
  always_comb begin
    norm_c = isToRound_i & ~f_i[EXT_F_W-1];
    unf_c  = isToRound_i & ((e_i == ZERO_E) | (norm_c & (e_i == 8'd1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      s1   <= 1'b0;
      rnd1 <= 1'b0;
      unf1 <= 1'b0;
      e1   <= '0;
      f1   <= '0;
    end else begin
      v1 <= valid_i;
      if (valid_i) begin
        s1   <= s_i;
        rnd1 <= isToRound_i;
        unf1 <= unf_c;
        e1   <= norm_c ? e_i - 8'd1 : e_i;
        f1   <= norm_c ? {f_i[EXT_F_W-2:0], 1'b0} : f_i;
      end
    end
  end

  assign entry_c = round_pack_sqrt(s1, e1, f1, rnd1, unf1);
  assign pop_c   = ~empty & ready_i;

  lamp_fpu_sqrt_round_pack_res_fifo #(
    .WIDTH (RES_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push   (v1),
    .din    (entry_c),
    .pop    (pop_c),
    .head_c (head_raw_c),
    .full   (full),
    .empty  (empty)
  );

  // A stage-2 result meeting a full FIFO with no pop is lost for good.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overrun <= 1'b0;
    else if (v1 & full & ~pop_c) overrun <= 1'b1;
  end

  assign head_c    = res_entry_t'(head_raw_c);
  assign valid_o   = ~empty;
  assign res_o     = empty ? '0 : head_c.res;
  assign inexact_o = ~empty & head_c.inexact;
  assign ovf_o     = ~empty & head_c.ovf;
  assign unf_o     = ~empty & head_c.unf;
  assign overrun_o = overrun;

endmodule

// File: tb/tb_lamp_fpu_sqrt_round_pack.sv
// Randomized + directed bench for the sqrt round/pack back-end, checked
// against an integer rounding model and a queue-based buffer model.
module tb_lamp_fpu_sqrt_round_pack;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        s_i = 1'b0;
  logic [7:0]  e_i = '0;
  logic [11:0] f_i = '0;
  logic        is_to_round = 1'b0;
  logic        ready_i = 1'b1;
  logic [15:0] res_o;
  logic        inexact_o;
  logic        ovf_o;
  logic        unf_o;
  logic        valid_o;
  logic        overrun_o;

  int n_assert = 0;
  int n_fail   = 0;

  lamp_fpu_sqrt_round_pack #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .s_i         (s_i),
    .e_i         (e_i),
    .f_i         (f_i),
    .isToRound_i (is_to_round),
    .res_o       (res_o),
    .inexact_o   (inexact_o),
    .ovf_o       (ovf_o),
    .unf_o       (unf_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result as {res[15:0], inexact, ovf, unf}, computed with integer arithmetic.
  function automatic logic [18:0] ref_out(input logic s, input logic [7:0] e,
                                          input logic [11:0] f, input logic rnd);
    int   ex;
    int   m;
    int   keep;
    int   rem;
    logic inx;
    if (!rnd) return {s, e, f[11:5], 3'b000};
    ex = int'(e);
    m  = int'(f);
    if (m < 2048) begin
      m  = m * 2;
      ex = ex - 1;
    end
    if (ex <= 0) return {s, 8'h00, 7'h00, 3'b101};
    keep = 128 + (m / 16) % 128;
    rem  = m % 16;
    inx  = (rem != 0);
    if (rem > 8 || (rem == 8 && keep % 2 == 1)) keep++;
    if (keep == 256) begin
      keep = 128;
      ex++;
    end
    if (ex >= 255) return {s, 8'hFF, 7'h00, 3'b110};
    return {s, 8'(ex), 7'(keep % 128), inx, 2'b00};
  endfunction

  // Buffer model: one-cycle stage, then a DEPTH-entry queue.
  logic [18:0] mq[$];
  logic        st_v = 1'b0;
  logic [18:0] st_d = '0;
  logic        m_ovr = 1'b0;
  logic        m_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      st_v  = 1'b0;
      m_ovr = 1'b0;
    end else begin
      m_pop = (mq.size() > 0) && ready_i;
      if (m_pop) void'(mq.pop_front());
      if (st_v) begin
        if (mq.size() < DEPTH) mq.push_back(st_d);
        else m_ovr = 1'b1;
      end
      st_v = valid_i;
      st_d = ref_out(s_i, e_i, f_i, is_to_round);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_outputs", {12'h0, res_o, inexact_o, ovf_o, unf_o, valid_o, overrun_o}, 32'h0);
    end else begin
      chk("valid_o", 32'(valid_o), 32'(mq.size() > 0));
      if (mq.size() > 0)
        chk("head", 32'({res_o, inexact_o, ovf_o, unf_o}), 32'(mq[0]));
      chk("overrun_o", 32'(overrun_o), 32'(m_ovr));
    end
  end

  task automatic drive(input logic s, input logic [7:0] e, input logic [11:0] f, input logic r);
    valid_i     = 1'b1;
    s_i         = s;
    e_i         = e;
    f_i         = f;
    is_to_round = r;
  endtask

  task automatic drive_rand();
    logic [7:0] e;
    case ($urandom_range(0, 7))
      0: e = 8'd0;
      1: e = 8'd1;
      2: e = 8'd254;
      3: e = 8'd255;
      4: e = 8'd127;
      default: e = 8'($urandom);
    endcase
    drive(1'($urandom), e, 12'($urandom), ($urandom_range(0, 9) != 0));
  endtask

  logic [0:0]  dv_s [8];
  logic [7:0]  dv_e [8];
  logic [11:0] dv_f [8];
  logic [0:0]  dv_r [8];
  logic [18:0] dv_x [8];
  int          pops;

  initial begin
    dv_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dv_e = '{8'd128, 8'd128, 8'd128, 8'd127, 8'd254, 8'hFF, 8'd0, 8'd1};
    dv_f = '{12'h800, 12'h818, 12'h828, 12'hFFC, 12'hFFC, 12'h800, 12'h800, 12'h400};
    dv_r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    dv_x = '{{16'h4000, 3'b000}, {16'h4002, 3'b100}, {16'h4002, 3'b100},
             {16'h4000, 3'b100}, {16'h7F80, 3'b110}, {16'h7FC0, 3'b000},
             {16'h0000, 3'b101}, {16'h8000, 3'b101}};

    @(negedge clk);
    #2 chk("reset_state", {12'h0, res_o, inexact_o, ovf_o, unf_o, valid_o, overrun_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Hand-computed vectors: pin the model and the DUT head two cycles later.
    for (int i = 0; i < 8; i++) begin
      chk("model_pin", 32'(ref_out(dv_s[i], dv_e[i], dv_f[i], dv_r[i])), 32'(dv_x[i]));
      @(negedge clk);
      drive(dv_s[i], dv_e[i], dv_f[i], dv_r[i]);
      @(negedge clk);
      valid_i = 1'b0;
      #2 chk("latency_n1_valid", 32'(valid_o), 32'h0);
      @(negedge clk);
      #2 chk("directed_head", 32'({res_o, inexact_o, ovf_o, unf_o}), 32'(dv_x[i]));
      chk("directed_valid", 32'(valid_o), 32'h1);
    end

    // Backpressure: five results into a four-deep buffer.
    @(negedge clk);
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_rand();
      @(negedge clk);
    end
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 chk("bp_overrun", 32'(overrun_o), 32'h1);
    chk("bp_valid", 32'(valid_o), 32'h1);
    ready_i = 1'b1;
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      if (valid_o && ready_i) pops++;
      @(negedge clk);
      #2;
    end
    chk("bp_pops", 32'(pops), 32'd4);

    // Reset mid-stream: two buffered, one in flight.
    @(negedge clk);
    ready_i = 1'b0;
    drive_rand();
    @(negedge clk);
    drive_rand();
    @(negedge clk);
    drive_rand();
    @(posedge clk);
    #1 rst = 1'b0;
    valid_i = 1'b0;
    #1 chk("async_rst", {12'h0, res_o, inexact_o, ovf_o, unf_o, valid_o, overrun_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ready_i = 1'b1;
    repeat (4) @(negedge clk);
    #2 chk("no_ghost_after_rst", 32'(valid_o), 32'h0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) < 7) drive_rand();
      else valid_i = 1'b0;
      ready_i = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (10) @(negedge clk);
    #2 chk("drained", 32'(valid_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lamp_fpu_sqrt_round_pack.md
# lamp_fpu_sqrt_round_pack

Result back-end for the square-root unit: consumes its unrounded sign/exponent/extended-significand stream and delivers finished bfloat16 words. Normalizes, rounds to nearest-even, detects overflow and underflow, and packs the 16-bit result. Buffers results in a small FIFO behind a valid/ready handshake toward the register-file writeback. The sqrt unit cannot stall, so when the FIFO is full an arriving result is dropped and a sticky overrun is raised.

## Interface
- FIFO_DEPTH, 4, result buffer entries (power of two, ≥2)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- valid_i  input  1  result strobe from sqrt unit, one cycle per result
- s_i  input  1  result sign
- e_i  input  8  biased result exponent
- f_i  input  12  extended significand: [11] hidden, [10:4] fraction, [3] guard, [2] round, [1:0] sticky bits
- isToRound_i  input  1  1 = normal path; 0 = special value already encoded (fraction in f_i[11:5])
- res_o  output  16  packed bfloat16 {s, e[7:0], f[6:0]}
- inexact_o  output  1  G|R|S nonzero for res_o
- ovf_o  output  1  res_o is overflow-to-infinity
- unf_o  output  1  res_o is flushed-to-zero underflow
- valid_o  output  1  FIFO head valid
- ready_i  input  1  consumer accepts head when valid_o & ready_i
- overrun_o  output  1  sticky: a result was dropped on full FIFO

## Operation
- Stage 1 (registered on valid_i): if f_i[11]=0 on the normal path, shift significand left by one, exponent minus one (single step only). Sticky S = |f_i[1:0]. LSB = frac[0]. Round-up = G & (R | S | LSB).
- Stage 2: frac8 = {1,frac} + round-up (8-bit add with carry). Carry out → frac = 0, exponent + 1.
- Exponent after rounding ≥ 255 → result {s, 0xFF, 0}, ovf=1, inexact=1.
- Exponent = 0, or decrement underflows below 0 → {s, 0x00, 0}, unf=1, inexact=1 (no subnormals).
- isToRound_i = 0: pass {s_i, e_i, f_i[11:5]} unmodified; all three flags 0.
- Stage 2 output writes the FIFO as {res, inexact, ovf, unf}. FIFO is show-ahead: head drives outputs directly.
- Write with FIFO full and no simultaneous pop → entry discarded, overrun_o set. Stays set until reset.
- Write and pop in the same cycle on a full FIFO → both succeed, no overrun.
- Pop on empty is ignored.

## Timing
- Reset values: res_o=0, inexact_o=0, ovf_o=0, unf_o=0, valid_o=0, overrun_o=0. Pipeline valids and FIFO pointers cleared.
- Reset asserted mid-operation discards all in-flight and buffered results immediately.
- Latency: valid_i high in cycle N → FIFO written at end of N+1 → valid_o high in cycle N+2 if the FIFO was empty.
- Throughput: one result per cycle. The pipeline never stalls; ready_i affects only the FIFO read side.
- Outputs hold stable while valid_o=1 and ready_i=0.
- Pop at the end of cycle M exposes the next entry in cycle M+1.

## Structure
- lampFPU_pkg gains FUNC_roundPackSqrt (stage-2 arithmetic) and the constants RND_GRS_W=3 and BF16_W=16. It reuses the existing LAMP_FLOAT_* widths and the INF/ZERO encodings.
- One submodule: lampFPU_resFifo. It is a generic synchronous FIFO with async active-low reset, parameterized by width and depth, with full/empty/push/pop ports.
- Top level: two pipeline registers plus overrun logic.

## Test plan
- sqrt(4.0): s=0, e=128, f=0x800, isToRound=1 → res_o=0x4000, inexact=0, in cycle N+2.
- Tie to even: e=128, f=12'b1000_0001_1000 → frac LSB odd, round up → res_o=0x4002, inexact=1. Same input with frac 0000010 and G=1 only → 0x4002, no increment.
- Carry out: e=127, f=12'b1111_1111_1100 → res_o=0x4000. Same f with e=254 → res_o=0x7F80, ovf=1.
- Special pass-through: isToRound=0, s=0, e=0xFF, f={7'b1000000,5'b0} → res_o=0x7FC0, all flags 0.
- Backpressure: ready_i=0, five back-to-back results → first four held in order, fifth dropped, overrun_o=1. Then ready_i=1 → four pops in order, valid_o drops after the fourth.
- Reset mid-stream: assert rst low with 2 entries buffered and 1 in flight → all outputs 0 asynchronously. No result appears after release.
